// File: rtl/rv_operand_stage.sv
// Operand-fetch stage: issues regfile reads, resolves writeback hazards, and holds operands through execute stalls.
// Latency is 1 cycle from accept to ex_valid; it holds the op in a one-entry slot while ex_ready is low.
module rv_operand_stage #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [AW-1:0]    id_rs1_addr,
  input  logic [AW-1:0]    id_rs2_addr,
  input  logic [TAG_W-1:0] id_tag,
  output logic [AW-1:0]    rf_rs1_addr,
  output logic [AW-1:0]    rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             wb_wen,
  input  logic [AW-1:0]    wb_waddr,
  input  logic [XLEN-1:0]  wb_wdata,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_rs1,
  output logic [XLEN-1:0]  ex_rs2,
  output logic [TAG_W-1:0] ex_tag
);

  typedef enum logic [1:0] {EMPTY, FETCH, HOLD} state_t;

  state_t          state;
  logic [AW-1:0]   rs1_q, rs2_q;
  logic            byp_flag1, byp_flag2;
  logic [XLEN-1:0] byp_data1, byp_data2;
  logic [XLEN-1:0] hold1, hold2;
  logic [XLEN-1:0] base1, base2;
  logic            accept, live1, live2, snoop1, snoop2;

  assign rf_rs1_addr = id_rs1_addr;
  assign rf_rs2_addr = id_rs2_addr;

  assign ex_valid = (state != EMPTY);
  assign id_ready = !rst && !flush && ((state == EMPTY) || (ex_valid && ex_ready));
  assign accept   = id_valid && id_ready;

  // The regfile returns pre-write data, so a write in the address cycle must be captured here.
  assign snoop1 = wb_wen && (wb_waddr == id_rs1_addr) && (id_rs1_addr != '0);
  assign snoop2 = wb_wen && (wb_waddr == id_rs2_addr) && (id_rs2_addr != '0);
  assign live1  = wb_wen && (wb_waddr == rs1_q) && (rs1_q != '0);
  assign live2  = wb_wen && (wb_waddr == rs2_q) && (rs2_q != '0);

  always_comb begin
    base1 = hold1;
    base2 = hold2;
    if (state == FETCH) begin
      base1 = byp_flag1 ? byp_data1 : rf_rs1_data;
      base2 = byp_flag2 ? byp_data2 : rf_rs2_data;
    end
    ex_rs1 = (rs1_q == '0) ? '0 : (live1 ? wb_wdata : base1);
    ex_rs2 = (rs2_q == '0) ? '0 : (live2 ? wb_wdata : base2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      rs1_q     <= '0;
      rs2_q     <= '0;
      byp_flag1 <= 1'b0;
      byp_flag2 <= 1'b0;
      byp_data1 <= '0;
      byp_data2 <= '0;
      hold1     <= '0;
      hold2     <= '0;
      ex_tag    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      byp_flag1 <= 1'b0;
      byp_flag2 <= 1'b0;
    end else if (accept) begin
      state     <= FETCH;
      rs1_q     <= id_rs1_addr;
      rs2_q     <= id_rs2_addr;
      ex_tag    <= id_tag;
      byp_flag1 <= snoop1;
      byp_flag2 <= snoop2;
      byp_data1 <= wb_wdata;
      byp_data2 <= wb_wdata;
    end else if (ex_valid && ex_ready) begin
      state     <= EMPTY;
      byp_flag1 <= 1'b0;
      byp_flag2 <= 1'b0;
    end else if (ex_valid) begin
      // Stalled: keep the resolved operands, which already fold in any matching writeback.
      state <= HOLD;
      hold1 <= ex_rs1;
      hold2 <= ex_rs2;
    end
  end

endmodule

// File: tb/tb_rv_operand_stage.sv
// Directed bench for rv_operand_stage with a pre-write-data regfile model.
module tb_rv_operand_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0;
  logic [31:0] id_tag = '0;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] ex_rs1, ex_rs2, ex_tag;

  int checks = 0;
  int errors = 0;
  logic [31:0] regs [32];

  rv_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_tag(id_tag),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_tag(ex_tag)
  );

  always #5 clk = ~clk;

  // Registered-read regfile; deliberately writes x0 too so the stage must force zero itself.
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) begin
    rf_rs1_data <= regs[rf_rs1_addr];
    rf_rs2_data <= regs[rf_rs2_addr];
    if (wb_wen) regs[wb_waddr] <= wb_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic test_reset();
    settle();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_id_ready got %0b want 0", id_ready); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %0b want 0", ex_valid); end
    checks++; if (ex_rs1 !== 32'h0 || ex_rs2 !== 32'h0 || ex_tag !== 32'h0) begin
      errors++; $display("FAIL rst_regs got %h %h %h want 0 0 0", ex_rs1, ex_rs2, ex_tag); end
    tick(); rst = 1'b0; settle();
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL post_rst_id_ready got %0b want 1", id_ready); end
  endtask

  task automatic test_rf_read();
    tick(); wb_wen = 1; wb_waddr = 5; wb_wdata = 32'h1111_0000;
    tick(); wb_wen = 0;
    tick(); tick();
    id_valid = 1; id_rs1_addr = 5; id_rs2_addr = 0; id_tag = 32'h100;
    tick(); id_valid = 0; settle();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rf_valid got %0b want 1", ex_valid); end
    checks++; if (ex_rs1 !== 32'h1111_0000) begin errors++; $display("FAIL rf_rs1 got %h want 11110000", ex_rs1); end
    checks++; if (ex_rs2 !== 32'h0) begin errors++; $display("FAIL rf_rs2 got %h want 0", ex_rs2); end
    checks++; if (ex_tag !== 32'h100) begin errors++; $display("FAIL rf_tag got %h want 100", ex_tag); end
    tick(); settle();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rf_retire got %0b want 0", ex_valid); end
  endtask

  task automatic test_latched_bypass();
    tick();
    id_valid = 1; id_rs1_addr = 7; id_rs2_addr = 7; id_tag = 32'h200;
    wb_wen = 1; wb_waddr = 7; wb_wdata = 32'hDEAD_BEEF;
    tick(); id_valid = 0; wb_wen = 0; settle();
    checks++; if (ex_rs1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL latched_rs1 got %h want deadbeef", ex_rs1); end
    checks++; if (ex_rs2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL latched_rs2_same got %h want deadbeef", ex_rs2); end
  endtask

  task automatic test_live_bypass();
    tick();
    id_valid = 1; id_rs1_addr = 0; id_rs2_addr = 9; id_tag = 32'h300;
    tick(); id_valid = 0; wb_wen = 1; wb_waddr = 9; wb_wdata = 32'h0000_00AA; settle();
    checks++; if (ex_rs2 !== 32'hAA) begin errors++; $display("FAIL live_rs2 got %h want aa", ex_rs2); end
    tick(); wb_wen = 0;
  endtask

  task automatic test_stall();
    tick(); ex_ready = 0;
    id_valid = 1; id_rs1_addr = 3; id_rs2_addr = 0; id_tag = 32'h400;
    tick(); id_valid = 0; settle();
    checks++; if (ex_valid !== 1'b1 || ex_rs1 !== 32'h0) begin
      errors++; $display("FAIL stall1 got v=%0b rs1=%h want v=1 rs1=0", ex_valid, ex_rs1); end
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_id_ready got %0b want 0", id_ready); end
    tick(); wb_wen = 1; wb_waddr = 3; wb_wdata = 32'h55; settle();
    checks++; if (ex_rs1 !== 32'h55) begin errors++; $display("FAIL stall2_live got %h want 55", ex_rs1); end
    tick(); wb_wen = 0; settle();
    checks++; if (ex_rs1 !== 32'h55 || ex_tag !== 32'h400) begin
      errors++; $display("FAIL stall3_hold got rs1=%h tag=%h want 55 400", ex_rs1, ex_tag); end
    tick(); ex_ready = 1; settle();
    checks++; if (ex_valid !== 1'b1 || ex_rs1 !== 32'h55) begin
      errors++; $display("FAIL stall_release got v=%0b rs1=%h want 1 55", ex_valid, ex_rs1); end
    tick(); settle();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL stall_retire got %0b want 0", ex_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tags [3];
    tags[0] = 32'hA; tags[1] = 32'hB; tags[2] = 32'hC;
    tick();
    id_valid = 1; id_rs1_addr = 5; id_rs2_addr = 3; id_tag = tags[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) id_tag = tags[i+1]; else id_valid = 0;
      settle();
      checks++; if (ex_valid !== 1'b1 || ex_tag !== tags[i] || ex_rs1 !== 32'h1111_0000 || ex_rs2 !== 32'h55) begin
        errors++; $display("FAIL b2b_%0d got v=%0b tag=%h rs1=%h rs2=%h want 1 %h 11110000 55",
                           i, ex_valid, ex_tag, ex_rs1, ex_rs2, tags[i]); end
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %0b want 1", i, id_ready); end
    end
    tick(); settle();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", ex_valid); end
  endtask

  task automatic test_x0();
    tick();
    id_valid = 1; id_rs1_addr = 0; id_rs2_addr = 0; id_tag = 32'h600;
    wb_wen = 1; wb_waddr = 0; wb_wdata = 32'hFFFF;
    tick(); settle();
    checks++; if (ex_rs1 !== 32'h0 || ex_rs2 !== 32'h0) begin
      errors++; $display("FAIL x0_wb got %h %h want 0 0", ex_rs1, ex_rs2); end
    wb_wen = 0; id_tag = 32'h601;
    tick(); id_valid = 0; settle();
    checks++; if (ex_rs1 !== 32'h0 || ex_tag !== 32'h601) begin
      errors++; $display("FAIL x0_rf got rs1=%h tag=%h want 0 601", ex_rs1, ex_tag); end
    tick();
  endtask

  task automatic test_flush();
    tick(); ex_ready = 0;
    id_valid = 1; id_rs1_addr = 5; id_rs2_addr = 0; id_tag = 32'h700;
    tick(); id_valid = 0;
    tick(); flush = 1; id_valid = 1; id_tag = 32'h701; settle();
    checks++; if (id_ready !== 1'b0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL flush_cycle got rdy=%0b v=%0b want 0 1", id_ready, ex_valid); end
    tick(); flush = 0; id_valid = 0; ex_ready = 1; settle();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", ex_valid); end
    checks++; if (ex_tag !== 32'h700) begin errors++; $display("FAIL flush_no_accept got tag=%h want 700", ex_tag); end
  endtask

  task automatic test_reset_mid_op();
    tick();
    id_valid = 1; id_rs1_addr = 5; id_rs2_addr = 0; id_tag = 32'h800;
    tick(); id_valid = 0; rst = 1; settle();
    checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst got v=%0b rdy=%0b want 0 0", ex_valid, id_ready); end
    tick(); rst = 0; settle();
    checks++; if (ex_valid !== 1'b0 || ex_tag !== 32'h0) begin
      errors++; $display("FAIL mid_rst_after got v=%0b tag=%h want 0 0", ex_valid, ex_tag); end
  endtask

  initial begin
    test_reset();
    test_rf_read();
    test_latched_bypass();
    test_live_bypass();
    test_stall();
    test_back_to_back();
    test_x0();
    test_flush();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
